// File: rtl/ex_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// ex_muldiv_sequencer: EX-stage multi-cycle unsigned multiply / restoring divide.
// Optional build macro: MULDIV_EARLY_EXIT_EN. Revision: 1.0
// ============================================================================
module ex_muldiv_sequencer #(
  parameter int         WIDTH    = 32,
  parameter logic [5:0] FUNC_MUL = 6'b000010,
  parameter logic [5:0] FUNC_DIV = 6'b000001
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [2:0]       flag
);

  localparam int         CW        = $clog2(WIDTH) + 1;
  localparam logic [2:0] FLAG_NONE = 3'b000;
  localparam logic [2:0] FLAG_EXC  = 3'b010;
  localparam logic [2:0] FLAG_OVF  = 3'b011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quot_q, quot_d;
  logic [WIDTH-1:0]     divisor_q, divisor_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [WIDTH-1:0]     result_hi_q, result_hi_d;
  logic [2:0]           flag_q, flag_d;

  logic                 is_muldiv;
  logic                 last_step;
  logic                 mul_finish;
  logic [WIDTH:0]       trial;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_div_d    = is_div_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    prod_d      = prod_q;
    rem_d       = rem_q;
    quot_d      = quot_q;
    divisor_d   = divisor_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    flag_d      = flag_q;
    mul_finish  = 1'b0;

    is_muldiv = (func == FUNC_MUL) || (func == FUNC_DIV);
    last_step = (cnt_q == CW'(WIDTH - 1));
    // Partial remainder needs one extra bit; the top bit of the difference is the borrow.
    trial     = {rem_q, quot_q[WIDTH-1]} - {1'b0, divisor_q};

    case (state_q)
      S_IDLE: begin
        if (start && is_muldiv && !flush) begin
          is_div_d  = (func == FUNC_DIV);
          cnt_d     = '0;
          mcand_d   = {{WIDTH{1'b0}}, data_a};
          mplier_d  = data_b;
          prod_d    = '0;
          rem_d     = '0;
          quot_d    = data_a;
          divisor_d = data_b;
          if ((func == FUNC_DIV) && (data_b == '0)) begin
            state_d     = S_DONE;
            result_d    = '1;
            result_hi_d = data_a;
            flag_d      = FLAG_EXC;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + CW'(1);
        if (is_div_q) begin
          if (!trial[WIDTH]) begin
            rem_d  = trial[WIDTH-1:0];
            quot_d = {quot_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d  = {rem_q[WIDTH-2:0], quot_q[WIDTH-1]};
            quot_d = {quot_q[WIDTH-2:0], 1'b0};
          end
          if (last_step) begin
            state_d     = S_DONE;
            result_d    = quot_d;
            result_hi_d = rem_d;
            flag_d      = FLAG_NONE;
          end
        end else begin
          prod_d   = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
          mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
          mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
`ifdef MULDIV_EARLY_EXIT_EN
          mul_finish = last_step || (mplier_d == '0);
`else
          mul_finish = last_step;
`endif
          if (mul_finish) begin
            state_d     = S_DONE;
            result_d    = prod_d[WIDTH-1:0];
            result_hi_d = prod_d[2*WIDTH-1:WIDTH];
            flag_d      = (prod_d[2*WIDTH-1:WIDTH] != '0) ? FLAG_OVF : FLAG_NONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Flush wins over everything and leaves the visible outputs untouched.
    if (flush) begin
      state_d     = S_IDLE;
      result_d    = result_q;
      result_hi_d = result_hi_q;
      flag_d      = flag_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      is_div_q    <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      prod_q      <= '0;
      rem_q       <= '0;
      quot_q      <= '0;
      divisor_q   <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      flag_q      <= FLAG_NONE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_div_q    <= is_div_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      prod_q      <= prod_d;
      rem_q       <= rem_d;
      quot_q      <= quot_d;
      divisor_q   <= divisor_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      flag_q      <= flag_d;
    end
  end

  assign busy      = (state_q == S_BUSY);
  assign done      = (state_q == S_DONE);
  assign stall     = busy || ((state_q == S_IDLE) && start && is_muldiv && !flush);
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign flag      = flag_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_sequencer.sv
`default_nettype none
// Bench for ex_muldiv_sequencer: per-cycle arithmetic reference model plus directed literal checks.
module tb_ex_muldiv_sequencer;

  localparam logic [5:0] F_MUL = 6'b000010;
  localparam logic [5:0] F_DIV = 6'b000001;
  localparam logic [5:0] F_ADD = 6'b100000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  func = '0;
  logic [31:0] data_a = '0;
  logic [31:0] data_b = '0;
  logic        flush = 1'b0;
  logic        stall, busy, done;
  logic [31:0] result, result_hi;
  logic [2:0]  flag;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  ex_muldiv_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .func(func),
    .data_a(data_a), .data_b(data_b), .flush(flush),
    .stall(stall), .busy(busy), .done(done),
    .result(result), .result_hi(result_hi), .flag(flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Number of BUSY cycles a multiply occupies for a given multiplier.
  function automatic int mul_busy(input logic [31:0] b);
    int k;
    k = 1;
`ifdef MULDIV_EARLY_EXIT_EN
    for (int i = 0; i < 32; i++) if (b[i]) k = i + 1;
`else
    k = 32;
`endif
    return k;
  endfunction

  // Reference model: remaining busy cycles, a done flag and the architectural outputs.
  int          m_left = 0;
  bit          m_done = 1'b0;
  bit          m_known = 1'b0;
  logic [31:0] m_res = '0, m_hi = '0;
  logic [2:0]  m_flag = '0;
  logic [31:0] p_res = '0, p_hi = '0;
  logic [2:0]  p_flag = '0;

  always @(negedge clk) begin : model
    bit          idle, ismd, acc, e_busy, e_stall;
    logic [63:0] prod;
    idle    = (m_left == 0) && !m_done;
    ismd    = (func == F_MUL) || (func == F_DIV);
    acc     = idle && start && ismd && !flush;
    e_busy  = (m_left > 0);
    e_stall = e_busy || acc;
    if (m_known) begin
      checks++;
      if ({busy, done, stall, result, result_hi, flag} !==
          {e_busy, m_done, e_stall, m_res, m_hi, m_flag}) begin
        failures++;
        $display("FAIL cycle%0d: got busy=%b done=%b stall=%b res=%h hi=%h flag=%b; want busy=%b done=%b stall=%b res=%h hi=%h flag=%b",
                 cyc, busy, done, stall, result, result_hi, flag,
                 e_busy, m_done, e_stall, m_res, m_hi, m_flag);
      end
    end
    if (!reset) begin
      m_known <= 1'b1;
      m_left  <= 0;
      m_done  <= 1'b0;
      m_res   <= '0;
      m_hi    <= '0;
      m_flag  <= '0;
    end else if (flush) begin
      m_left <= 0;
      m_done <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1'b1;
        m_res  <= p_res;
        m_hi   <= p_hi;
        m_flag <= p_flag;
      end
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (acc) begin
      if (func == F_DIV) begin
        if (data_b == 0) begin
          m_done <= 1'b1;
          m_res  <= 32'hFFFF_FFFF;
          m_hi   <= data_a;
          m_flag <= 3'b010;
        end else begin
          m_left <= 32;
          p_res  <= data_a / data_b;
          p_hi   <= data_a % data_b;
          p_flag <= 3'b000;
        end
      end else begin
        prod   = 64'(data_a) * 64'(data_b);
        m_left <= mul_busy(data_b);
        p_res  <= prod[31:0];
        p_hi   <= prod[63:32];
        p_flag <= (prod[63:32] != 0) ? 3'b011 : 3'b000;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, output int n);
    start  = 1'b1;
    func   = f;
    data_a = a;
    data_b = b;
    n      = cyc;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit, output int dc,
                           output logic [31:0] r, output logic [31:0] h, output logic [2:0] fl);
    dc = -1;
    r  = '0;
    h  = '0;
    fl = '0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) begin
        dc = cyc;
        r  = result;
        h  = result_hi;
        fl = flag;
        break;
      end
    end
    if (dc < 0) begin
      failures++;
      $display("FAIL %s_timeout: got no done within %0d cycles, want done", name, limit);
    end
    step(1);
  endtask

  initial begin : stim
    int n, dc;
    logic [31:0] r, h;
    logic [2:0]  fl;

    step(3);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_outputs", {29'd0, busy, done, stall, result, result_hi[31:3], flag},
        64'd0);
    step(1);

    // 7 x 6
    issue(F_MUL, 32'd7, 32'd6, n);
    wait_done("mul7x6", 60, dc, r, h, fl);
`ifdef MULDIV_EARLY_EXIT_EN
    chk("mul7x6_latency", dc - n, 4);
`else
    chk("mul7x6_latency", dc - n, 33);
`endif
    chk("mul7x6_result", {r, h}, {32'd42, 32'd0});
    chk("mul7x6_flag", fl, 3'b000);

    // Overflow into the high word; a stray DIV start mid-run must be ignored.
    issue(F_MUL, 32'h0001_0000, 32'h0001_0000, n);
    step(4);
    start = 1'b1; func = F_DIV; data_a = 32'd9; data_b = 32'd0;
    step(1);
    start = 1'b0;
    wait_done("mul_ovf", 60, dc, r, h, fl);
    chk("mul_ovf_result", {r, h}, {32'd0, 32'd1});
    chk("mul_ovf_flag", fl, 3'b011);

    issue(F_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    wait_done("mul_max", 60, dc, r, h, fl);
    chk("mul_max_result", {r, h}, {32'h0000_0001, 32'hFFFF_FFFE});
    chk("mul_max_flag", fl, 3'b011);

    issue(F_DIV, 32'd100, 32'd7, n);
    wait_done("div100_7", 60, dc, r, h, fl);
    chk("div100_7_latency", dc - n, 33);
    chk("div100_7_result", {r, h}, {32'd14, 32'd2});
    chk("div100_7_flag", fl, 3'b000);

    issue(F_DIV, 32'd7, 32'd100, n);
    wait_done("div7_100", 60, dc, r, h, fl);
    chk("div7_100_result", {r, h}, {32'd0, 32'd7});

    issue(F_DIV, 32'hFFFF_FFFF, 32'd1, n);
    wait_done("div_max", 60, dc, r, h, fl);
    chk("div_max_result", {r, h}, {32'hFFFF_FFFF, 32'd0});

    issue(F_DIV, 32'd5, 32'd0, n);
    wait_done("div0", 10, dc, r, h, fl);
    chk("div0_latency", dc - n, 1);
    chk("div0_result", {r, h}, {32'hFFFF_FFFF, 32'd5});
    chk("div0_flag", fl, 3'b010);

    // Flush mid-multiply: no done pulse and outputs keep the divide-by-zero values.
`ifdef MULDIV_EARLY_EXIT_EN
    issue(F_MUL, 32'd3, 32'h8000_0003, n);
`else
    issue(F_MUL, 32'd3, 32'd3, n);
`endif
    step(9);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    @(negedge clk);
    chk("flush_idle", {busy, done}, 2'b00);
    step(40);
    chk("flush_keeps_result", {result, result_hi}, {32'hFFFF_FFFF, 32'd5});

    issue(F_MUL, 32'd3, 32'd3, n);
    wait_done("mul3x3", 60, dc, r, h, fl);
    chk("mul3x3_result", r, 32'd9);

    // Flush and start together in IDLE: nothing accepted.
    start = 1'b1; flush = 1'b1; func = F_MUL; data_a = 32'd2; data_b = 32'd2;
    @(negedge clk);
    chk("flush_start_stall", stall, 1'b0);
    step(1);
    start = 1'b0; flush = 1'b0;
    step(3);

    // Reset in the middle of a divide.
    issue(F_DIV, 32'd100, 32'd7, n);
    step(4);
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_mid_div", {busy, done, result, result_hi, flag}, 69'd0);
    step(40);

    // Non-muldiv func is not ours.
    start = 1'b1; func = F_ADD; data_a = 32'd1; data_b = 32'd1;
    @(negedge clk);
    chk("add_no_stall", stall, 1'b0);
    step(1);
    start = 1'b0;
    @(negedge clk);
    chk("add_stays_idle", busy, 1'b0);
    step(1);

    issue(F_MUL, 32'd9, 32'd3, n);
    wait_done("mul9x3", 60, dc, r, h, fl);
`ifdef MULDIV_EARLY_EXIT_EN
    chk("mul9x3_latency", dc - n, 3);
`else
    chk("mul9x3_latency", dc - n, 33);
`endif
    chk("mul9x3_result", {r, h, 29'd0, fl}, {32'd27, 32'd0, 32'd0});

    step(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
